// File: rtl/trd_pc_sched_if.sv
// Next-PC link between pc_sel (master) and the thread PC scheduler (slave).
// pc_sel drives per-thread next PCs and write enables, and consumes the issued slot.
interface trd_pc_sched_if;
   logic [31:0] nxt_pc_0;
   logic [31:0] nxt_pc_1;
   logic [31:0] nxt_pc_2;
   logic [31:0] nxt_pc_3;
   logic [31:0] nxt_pc_4;
   logic [31:0] nxt_pc_5;
   logic [31:0] nxt_pc_6;
   logic [31:0] nxt_pc_7;
   logic [7:0]  pc_wr;
   logic [2:0]  cur_trd;
   logic [31:0] cur_pc;
   logic        cur_vld;

   modport master (
      output nxt_pc_0, nxt_pc_1, nxt_pc_2, nxt_pc_3,
             nxt_pc_4, nxt_pc_5, nxt_pc_6, nxt_pc_7, pc_wr,
      input  cur_trd, cur_pc, cur_vld
   );

   modport slave (
      input  nxt_pc_0, nxt_pc_1, nxt_pc_2, nxt_pc_3,
             nxt_pc_4, nxt_pc_5, nxt_pc_6, nxt_pc_7, pc_wr,
      output cur_trd, cur_pc, cur_vld
   );
endinterface

// File: rtl/trd_pc_sched.sv
// Per-thread PC file and round-robin fetch scheduler for the 8-thread barrel core.
// Optional ISSUE_CNT_EN adds issue_cnt, a count of cycles with a valid issue slot.

module trd_pc_sched_trd #(
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        miss,
   input  logic        done,
   input  logic        wr,
   input  logic [31:0] nxt_pc,
   output logic [31:0] pc,
   output logic        rdy,
   output logic        elig
);
   typedef enum logic [1:0] {ST_OFF, ST_READY, ST_WAIT} st_t;

   st_t st_q, st_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q <= ST_OFF;
         pc   <= RESET_PC;
      end else begin
         st_q <= st_d;
         if (wr) pc <= nxt_pc;
      end
   end

   // A miss always wins over a same-cycle miss_done.
   always_comb begin
      st_d = st_q;
      if (!en) begin
         st_d = ST_OFF;
      end else begin
         case (st_q)
            ST_OFF:   st_d = ST_READY;
            ST_READY: if (miss) st_d = ST_WAIT;
            ST_WAIT:  if (!miss && done) st_d = ST_READY;
            default:  st_d = ST_OFF;
         endcase
      end
   end

   assign rdy  = (st_q == ST_READY);
   assign elig = rdy && !miss && en;
endmodule

module trd_pc_sched #(
   parameter logic [31:0] RESET_PC = 32'h0,
   parameter int          NUM_TRD  = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   trd_pc_sched_if.slave      pcs,
   input  logic [NUM_TRD-1:0] trd_en,
   input  logic               i_miss,
   input  logic [2:0]         i_miss_trd,
   input  logic               d_miss,
   input  logic [2:0]         d_miss_trd,
   input  logic [NUM_TRD-1:0] miss_done,
   input  logic               stall_fetch,
   output logic [NUM_TRD-1:0] trd_rdy
`ifdef ISSUE_CNT_EN
   ,
   output logic [31:0]        issue_cnt
`endif
);
   localparam int TW = 3;

   logic [NUM_TRD-1:0][31:0] nxt_pc;
   logic [NUM_TRD-1:0][31:0] pc_q;
   logic [NUM_TRD-1:0]       miss_hit;
   logic [NUM_TRD-1:0]       elig;
   logic [TW-1:0]            cur_trd_q;
   logic                     cur_vld_q;
   logic [TW-1:0]            nxt_trd;
   logic                     nxt_any;
   logic [TW-1:0]            idx;

   assign nxt_pc = {pcs.nxt_pc_7, pcs.nxt_pc_6, pcs.nxt_pc_5, pcs.nxt_pc_4,
                    pcs.nxt_pc_3, pcs.nxt_pc_2, pcs.nxt_pc_1, pcs.nxt_pc_0};

   for (genvar t = 0; t < NUM_TRD; t++) begin : g_trd
      assign miss_hit[t] = (i_miss && (i_miss_trd == TW'(t))) ||
                           (d_miss && (d_miss_trd == TW'(t)));

      trd_pc_sched_trd #(.RESET_PC(RESET_PC)) u_trd (
         .clk    (clk),
         .rst_n  (rst_n),
         .en     (trd_en[t]),
         .miss   (miss_hit[t]),
         .done   (miss_done[t]),
         .wr     (pcs.pc_wr[t]),
         .nxt_pc (nxt_pc[t]),
         .pc     (pc_q[t]),
         .rdy    (trd_rdy[t]),
         .elig   (elig[t])
      );
   end

   // Scan farthest-first so the nearest eligible thread after cur_trd wins;
   // offset NUM_TRD wraps to cur_trd itself, giving it lowest priority.
   always_comb begin
      nxt_trd = cur_trd_q;
      nxt_any = 1'b0;
      idx     = '0;
      for (int k = NUM_TRD; k >= 1; k--) begin
         idx = cur_trd_q + TW'(k);
         if (elig[idx]) begin
            nxt_trd = idx;
            nxt_any = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_trd_q <= TW'(NUM_TRD - 1);
         cur_vld_q <= 1'b0;
      end else if (!stall_fetch && nxt_any) begin
         cur_trd_q <= nxt_trd;
         cur_vld_q <= 1'b1;
      end else begin
         cur_vld_q <= 1'b0;
      end
   end

   // Idle slots present PC-1 so pc_sel's unconditional +1 rewrites the same PC.
   assign pcs.cur_trd = cur_trd_q;
   assign pcs.cur_vld = cur_vld_q;
   assign pcs.cur_pc  = pc_q[cur_trd_q] - {31'b0, ~cur_vld_q};

`ifdef ISSUE_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         issue_cnt <= 32'h0;
      else if (cur_vld_q) issue_cnt <= issue_cnt + 32'd1;
   end
`endif
endmodule
